// File: rtl/line_buf_flt.sv
// Ping-pong scanline buffer: the writer fills one bank while the reader
// replays the previous line from the other bank once per filter pass.
module line_buf_flt #(
    parameter int SIZE     = 1024,
    parameter int DATA_WD  = 32,
    parameter int PASS_MAX = 5,
    parameter int SIZE_WD  = $clog2(SIZE),
    parameter int PASS_WD  = $clog2(PASS_MAX)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic [SIZE_WD-1:0] cfg_w_i,
    input  logic [PASS_WD-1:0] cfg_pass_i,
    input  logic               wr_val_i,
    input  logic [DATA_WD-1:0] wr_dat_i,
    output logic               wr_rdy_o,
    output logic               rd_val_o,
    input  logic               rd_ack_i,
    output logic [DATA_WD-1:0] rd_dat_o,
    output logic               rd_last_o,
    output logic [PASS_WD-1:0] rd_pass_o,
    output logic               rd_done_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;

    logic [DATA_WD-1:0] mem [2*SIZE];

    logic [1:0]         state;
    logic [1:0]         state_d;
    logic [1:0]         full;
    logic [1:0]         full_d;
    logic               wr_bank;
    logic [SIZE_WD-1:0] wr_idx;
    logic               rd_bank;
    logic               rd_bank_d;
    logic [SIZE_WD-1:0] rd_idx;
    logic [SIZE_WD-1:0] rd_idx_d;
    logic [PASS_WD-1:0] rd_pass;
    logic [PASS_WD-1:0] rd_pass_d;
    logic               done_d;
    logic               ren;
    logic [SIZE_WD:0]   raddr;

    logic wr_acc;
    logic wr_end;
    logic ack;
    logic idx_end;
    logic pass_end;
    logic release_bank;
    logic next_rdy;

    assign wr_rdy_o     = !full[wr_bank];
    assign wr_acc       = wr_val_i & wr_rdy_o & !start_i;
    assign wr_end       = wr_acc & (wr_idx == cfg_w_i);
    assign rd_val_o     = (state == SHOW);
    assign ack          = rd_ack_i & rd_val_o;
    assign idx_end      = (rd_idx == cfg_w_i);
    assign pass_end     = (rd_pass == cfg_pass_i);
    assign release_bank = ack & idx_end & pass_end;
    assign rd_last_o    = rd_val_o & idx_end;
    assign rd_pass_o    = rd_pass;

    // Entry 0 of a bank whose last entry is being written now is already
    // in the RAM, so it can be prefetched without a read-during-write clash.
    assign next_rdy = full[!rd_bank]
                    | (wr_end & (wr_bank != rd_bank) & (cfg_w_i != '0));

    always_comb begin
        full_d = full;
        if (wr_end) begin
            full_d[wr_bank] = 1'b1;
        end
        if (release_bank) begin
            full_d[rd_bank] = 1'b0;
        end
    end

    always_comb begin
        state_d   = state;
        rd_idx_d  = rd_idx;
        rd_pass_d = rd_pass;
        rd_bank_d = rd_bank;
        done_d    = 1'b0;
        ren       = 1'b0;
        raddr     = {rd_bank, rd_idx};
        case (state)
            IDLE: begin
                if (full_d[rd_bank]) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ren     = 1'b1;
                state_d = SHOW;
            end
            SHOW: begin
                if (ack) begin
                    if (!idx_end) begin
                        rd_idx_d = rd_idx + 1'b1;
                    end else begin
                        rd_idx_d = '0;
                        if (!pass_end) begin
                            rd_pass_d = rd_pass + 1'b1;
                        end else begin
                            rd_pass_d = '0;
                            rd_bank_d = !rd_bank;
                            done_d    = 1'b1;
                        end
                    end
                    raddr = {rd_bank_d, rd_idx_d};
                    if (!release_bank || next_rdy) begin
                        ren = 1'b1;
                    end else if (full_d[rd_bank_d]) begin
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[{wr_bank, wr_idx}] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            full      <= '0;
            wr_bank   <= 1'b0;
            wr_idx    <= '0;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            rd_pass   <= '0;
            rd_done_o <= 1'b0;
            rd_dat_o  <= '0;
        end else if (start_i) begin
            state     <= IDLE;
            full      <= '0;
            wr_bank   <= 1'b0;
            wr_idx    <= '0;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            rd_pass   <= '0;
            rd_done_o <= 1'b0;
            rd_dat_o  <= '0;
        end else begin
            state     <= state_d;
            full      <= full_d;
            rd_bank   <= rd_bank_d;
            rd_idx    <= rd_idx_d;
            rd_pass   <= rd_pass_d;
            rd_done_o <= done_d;
            if (wr_acc) begin
                if (wr_end) begin
                    wr_idx  <= '0;
                    wr_bank <= !wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            if (ren) begin
                rd_dat_o <= mem[raddr];
            end
        end
    end

endmodule

// File: tb/tb_line_buf_flt.sv
// Directed bench for line_buf_flt: a write-side model pushes the expected
// replay stream into a scoreboard that is popped on every consumer ack.
module tb_line_buf_flt;

    logic        clk;
    logic        rstn;
    logic        start_i;
    logic [9:0]  cfg_w_i;
    logic [2:0]  cfg_pass_i;
    logic        wr_val_i;
    logic [31:0] wr_dat_i;
    logic        wr_rdy_o;
    logic        rd_val_o;
    logic        rd_ack_i;
    logic [31:0] rd_dat_o;
    logic        rd_last_o;
    logic [2:0]  rd_pass_o;
    logic        rd_done_o;

    line_buf_flt dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start_i),
        .cfg_w_i    (cfg_w_i),
        .cfg_pass_i (cfg_pass_i),
        .wr_val_i   (wr_val_i),
        .wr_dat_i   (wr_dat_i),
        .wr_rdy_o   (wr_rdy_o),
        .rd_val_o   (rd_val_o),
        .rd_ack_i   (rd_ack_i),
        .rd_dat_o   (rd_dat_o),
        .rd_last_o  (rd_last_o),
        .rd_pass_o  (rd_pass_o),
        .rd_done_o  (rd_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        last;
        logic [2:0]  pass;
        logic        fin;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] line_q[$];

    int checks = 0;
    int errors = 0;
    int n_rd = 0;
    int n_done = 0;
    int n_gap = 0;
    int n_rdy_low = 0;
    bit gap_on = 0;
    bit gap_seen = 0;
    bit done_exp = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and write-side model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            line_q.delete();
            done_exp = 0;
        end else begin
            chk("rd_done", rd_done_o, done_exp);
            done_exp = 0;
            if (rd_done_o) n_done++;
            if (!wr_rdy_o) n_rdy_low++;
            if (gap_on) begin
                if (rd_val_o) gap_seen = 1;
                else if (gap_seen && n_rd < 32) n_gap++;
            end
            if (start_i) begin
                exp_q.delete();
                line_q.delete();
            end else begin
                if (rd_val_o && rd_ack_i) begin
                    n_rd++;
                    if (exp_q.size() == 0) begin
                        chk("extra_rd", rd_val_o, 1'b0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rd_dat", rd_dat_o, e.d);
                        chk("rd_last", rd_last_o, e.last);
                        chk("rd_pass", rd_pass_o, e.pass);
                        done_exp = e.fin;
                    end
                end
                if (wr_val_i && wr_rdy_o) begin
                    line_q.push_back(wr_dat_i);
                    if (line_q.size() == int'(cfg_w_i) + 1) begin
                        for (int p = 0; p <= int'(cfg_pass_i); p++) begin
                            for (int i = 0; i <= int'(cfg_w_i); i++) begin
                                exp_q.push_back('{line_q[i],
                                    i == int'(cfg_w_i), 3'(p),
                                    i == int'(cfg_w_i) &&
                                    p == int'(cfg_pass_i)});
                            end
                        end
                        line_q.delete();
                    end
                end
            end
        end
    end

    task automatic new_frame(input int w, input int p);
        @(posedge clk); #1;
        cfg_w_i    = 10'(w);
        cfg_pass_i = 3'(p);
        start_i    = 1'b1;
        @(posedge clk); #1;
        start_i    = 1'b0;
        n_rd       = 0;
        n_done     = 0;
        n_rdy_low  = 0;
    endtask

    task automatic wr_beat(input logic [31:0] d);
        bit ok;
        ok       = 0;
        wr_val_i = 1'b1;
        wr_dat_i = d;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = wr_rdy_o;
            @(posedge clk); #1;
        end
        wr_val_i = 1'b0;
        if (!ok) chk("wr_stall", wr_rdy_o, 1'b1);
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rd_val_o) break;
        end
        chk("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int idx;
        bit acc;
        rstn       = 1'b0;
        start_i    = 1'b0;
        cfg_w_i    = '0;
        cfg_pass_i = '0;
        wr_val_i   = 1'b0;
        wr_dat_i   = '0;
        rd_ack_i   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_rdy", wr_rdy_o, 1'b1);
        chk("rst_rd_val", rd_val_o, 1'b0);
        chk("rst_rd_last", rd_last_o, 1'b0);
        chk("rst_rd_pass", rd_pass_o, 3'd0);
        chk("rst_rd_done", rd_done_o, 1'b0);
        chk("rst_rd_dat", rd_dat_o, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Single pass, four-entry line, consumer always ready.
        new_frame(3, 0);
        rd_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) wr_beat(32'h10 + 32'(i));
        @(negedge clk);
        chk("t1_lat_n1", rd_val_o, 1'b0);
        @(negedge clk);
        chk("t1_lat_n2", rd_val_o, 1'b1);
        wait_drain(50);
        chk("t1_reads", n_rd, 4);
        chk("t1_done", n_done, 1);

        // Five passes over a three-entry line.
        new_frame(2, 4);
        rd_ack_i = 1'b1;
        wr_beat(32'hA);
        wr_beat(32'hB);
        wr_beat(32'hC);
        wait_drain(100);
        chk("t2_reads", n_rd, 15);
        chk("t2_done", n_done, 1);
        chk("t2_rdy_low", n_rdy_low, 0);

        // Stalled consumer: both banks fill, third line is dropped.
        new_frame(1, 1);
        rd_ack_i = 1'b0;
        wr_beat(32'h31);
        wr_beat(32'h32);
        wr_beat(32'h41);
        wr_beat(32'h42);
        @(negedge clk);
        chk("t3_rdy_fall", wr_rdy_o, 1'b0);
        @(posedge clk); #1;
        wr_val_i = 1'b1;
        wr_dat_i = 32'hEE;
        repeat (3) begin
            @(negedge clk);
            chk("t3_drop_rdy", wr_rdy_o, 1'b0);
            chk("t3_hold_dat", rd_dat_o, 32'h31);
            chk("t3_hold_val", rd_val_o, 1'b1);
            @(posedge clk); #1;
        end
        wr_val_i = 1'b0;
        rd_ack_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_rdy_before", wr_rdy_o, 1'b0);
        @(posedge clk); #1;
        rd_ack_i = 1'b0;
        @(negedge clk);
        chk("t3_rdy_after", wr_rdy_o, 1'b1);
        chk("t3_next_val", rd_val_o, 1'b1);
        @(posedge clk); #1;
        rd_ack_i = 1'b1;
        wait_drain(50);
        chk("t3_reads", n_rd, 8);
        chk("t3_done", n_done, 2);

        // Streaming: four eight-entry lines, no bubble once started.
        new_frame(7, 0);
        rd_ack_i = 1'b1;
        gap_seen = 0;
        n_gap    = 0;
        gap_on   = 1;
        for (int i = 0; i < 32; i++) wr_beat(32'h100 + 32'(i));
        wait_drain(100);
        gap_on = 0;
        chk("t4_reads", n_rd, 32);
        chk("t4_gaps", n_gap, 0);
        chk("t4_done", n_done, 4);

        // One-entry lines, three passes, random consumer.
        new_frame(0, 2);
        rd_ack_i = 1'b0;
        idx      = 0;
        wr_val_i = 1'b1;
        wr_dat_i = 32'h50;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            acc = wr_val_i && wr_rdy_o;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 6) wr_dat_i = 32'h50 + 32'(idx);
                else wr_val_i = 1'b0;
            end
            rd_ack_i = 1'($urandom_range(0, 1));
            if (idx == 6 && exp_q.size() == 0 && !rd_val_o) break;
        end
        wr_val_i = 1'b0;
        rd_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_wrote", idx, 6);
        chk("t5_reads", n_rd, 18);
        chk("t5_done", n_done, 6);

        // Frame restart in the middle of pass 1.
        new_frame(3, 2);
        rd_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) wr_beat(32'h60 + 32'(i));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rd_val_o) break;
        end
        chk("t6_val", rd_val_o, 1'b1);
        @(posedge clk); #1;
        rd_ack_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rd_ack_i = 1'b0;
        @(negedge clk);
        chk("t6_mid_pass", rd_pass_o, 3'd1);
        chk("t6_mid_dat", rd_dat_o, 32'h62);
        chk("t6_mid_last", rd_last_o, 1'b0);
        @(posedge clk); #1;
        start_i  = 1'b1;
        rd_ack_i = 1'b1;
        @(posedge clk); #1;
        start_i  = 1'b0;
        rd_ack_i = 1'b0;
        @(negedge clk);
        chk("t6_clr_val", rd_val_o, 1'b0);
        chk("t6_clr_rdy", wr_rdy_o, 1'b1);
        chk("t6_clr_pass", rd_pass_o, 3'd0);
        chk("t6_clr_last", rd_last_o, 1'b0);
        chk("t6_clr_dat", rd_dat_o, 32'd0);
        n_rd   = 0;
        n_done = 0;
        @(posedge clk); #1;
        rd_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) wr_beat(32'h70 + 32'(i));
        wait_drain(100);
        chk("t6_reads", n_rd, 12);
        chk("t6_done", n_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
